// File: rtl/next_audio_sample_decoder.sv
// next_audio_sample_decoder
// Recognises NeXT sound command bytes, assembles 4-byte stereo samples
// (MSB first) into 32-bit words, buffers them in a small FIFO and hands
// out exactly one word per sender request. Also generates the start/end
// strobes and the 22 kHz rate level for the I2S sender.
//
// Optional build macro: DECODER_SILENCE_FILL_EN
//   defined   - a request on an empty FIFO returns a zero word with out_valid
//   undefined - a request on an empty FIFO only pulses underrun
//
// Assembler states:
//   state | meaning
//   IDLE  | waiting for a command; data bytes here are framing errors
//   B0    | sample command seen, expecting byte 0 (lands in [31:24])
//   B1    | expecting byte 1
//   B2    | expecting byte 2
//   B3    | expecting byte 3; completing it pushes the word
module next_audio_sample_decoder #(
    parameter int         DEPTH         = 4,
    parameter logic [7:0] CMD_START_44K = 8'hC7,
    parameter logic [7:0] CMD_START_22K = 8'hC5,
    parameter logic [7:0] CMD_END       = 8'hC4,
    parameter logic [7:0] CMD_SAMPLE    = 8'hC0
) (
    input  logic                     in_clk,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     rx_is_cmd,
    input  logic                     sample_req,
    output logic                     out_valid,
    output logic [31:0]              out_data,
    output logic                     audio_start_out,
    output logic                     audio_end_out,
    output logic                     audio_22k_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     framing_err,
    output logic                     underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] B0   = 3'd1;
    localparam logic [2:0] B1   = 3'd2;
    localparam logic [2:0] B2   = 3'd3;
    localparam logic [2:0] B3   = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [31:0]   asm_word;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic cmd_byte;
    logic data_byte;
    logic start_cmd;
    logic end_cmd;
    logic flush;
    logic frame_set;
    logic push;
    logic pop_req;
    logic fifo_empty;
    logic fifo_full;
    logic do_pop;
    logic do_push;
    logic ovf_set;
    logic [31:0] push_word;

    // Decode the current byte and resolve FIFO push/pop/flush for this cycle
    always_comb begin
        cmd_byte   = rx_valid && rx_is_cmd;
        data_byte  = rx_valid && !rx_is_cmd;
        start_cmd  = cmd_byte && (rx_data == CMD_START_44K || rx_data == CMD_START_22K);
        end_cmd    = cmd_byte && (rx_data == CMD_END);
        flush      = start_cmd || end_cmd;
        frame_set  = (cmd_byte && state != IDLE) || (data_byte && state == IDLE);
        push       = data_byte && state == B3;
        push_word  = {asm_word[23:0], rx_data};
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_LEVEL);
        // A flush discards whatever a request would have taken.
        pop_req    = sample_req && !flush;
        do_pop     = pop_req && !fifo_empty;
        // Popping a full FIFO frees the slot the concurrent push needs.
        do_push    = push && (!fifo_full || do_pop);
        ovf_set    = push && fifo_full && !do_pop;
    end

    // Assembler next state: a command always restarts framing
    always_comb begin
        state_nxt = state;
        if (cmd_byte) begin
            state_nxt = (rx_data == CMD_SAMPLE) ? B0 : IDLE;
        end else if (data_byte) begin
            case (state)
                B0:      state_nxt = B1;
                B1:      state_nxt = B2;
                B2:      state_nxt = B3;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Assembler state and byte shift register
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            asm_word <= '0;
        end else begin
            state <= state_nxt;
            if (data_byte && state != IDLE) begin
                asm_word <= push_word;
            end
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset
    always_ff @(posedge in_clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output word, strobes and status flags
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_data        <= '0;
            audio_start_out <= 1'b0;
            audio_end_out   <= 1'b0;
            audio_22k_out   <= 1'b0;
            overflow        <= 1'b0;
            framing_err     <= 1'b0;
            underrun        <= 1'b0;
        end else begin
            out_valid <= do_pop;
            if (do_pop) begin
                out_data <= mem[rd_ptr];
            end
`ifdef DECODER_SILENCE_FILL_EN
            else if (pop_req && fifo_empty) begin
                out_valid <= 1'b1;
                out_data  <= '0;
            end
`endif
            underrun        <= sample_req && fifo_empty;
            audio_start_out <= start_cmd;
            audio_end_out   <= end_cmd;
            if (start_cmd) begin
                audio_22k_out <= (rx_data == CMD_START_22K);
            end
            // A start clears the sticky flags; an error seen in the same
            // cycle (start arriving mid-sample) still gets recorded.
            if (ovf_set)        overflow <= 1'b1;
            else if (start_cmd) overflow <= 1'b0;
            if (frame_set)      framing_err <= 1'b1;
            else if (start_cmd) framing_err <= 1'b0;
        end
    end

    assign fifo_level = count;

endmodule

// File: tb/tb_next_audio_sample_decoder.sv
// Bench for next_audio_sample_decoder: directed scenarios followed by
// random byte traffic, every cycle compared against a queue-based model.
module tb_next_audio_sample_decoder;

    localparam int DEPTH = 4;

    logic        in_clk = 1'b0;
    logic        reset  = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_is_cmd = 1'b0;
    logic        sample_req = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        audio_start_out;
    logic        audio_end_out;
    logic        audio_22k_out;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        framing_err;
    logic        underrun;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [31:0] mq[$];
    logic [7:0]  parts[$];
    bit          collecting;
    logic        e_valid, e_start, e_end, e_22k, e_ovf, e_frm, e_under;
    logic [31:0] e_data;

    next_audio_sample_decoder #(.DEPTH(DEPTH)) dut (
        .in_clk(in_clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_is_cmd(rx_is_cmd),
        .sample_req(sample_req),
        .out_valid(out_valid), .out_data(out_data),
        .audio_start_out(audio_start_out), .audio_end_out(audio_end_out),
        .audio_22k_out(audio_22k_out), .fifo_level(fifo_level),
        .overflow(overflow), .framing_err(framing_err), .underrun(underrun)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        parts.delete();
        collecting = 0;
        e_valid = 0; e_start = 0; e_end = 0; e_22k = 0;
        e_ovf = 0; e_frm = 0; e_under = 0; e_data = '0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit c, input bit r);
        bit start, flush, fset;
        logic [31:0] word;
        e_valid = 0; e_start = 0; e_end = 0; e_under = 0;
        start = v && c && (d == 8'hC7 || d == 8'hC5);
        flush = start || (v && c && d == 8'hC4);
        fset  = v && (c ? collecting : !collecting);
        if (r) begin
            if (mq.size() == 0) begin
                e_under = 1;
`ifdef DECODER_SILENCE_FILL_EN
                if (!flush) begin
                    e_valid = 1;
                    e_data  = '0;
                end
`endif
            end else if (!flush) begin
                e_valid = 1;
                e_data  = mq.pop_front();
            end
        end
        if (v && !c && collecting) begin
            parts.push_back(d);
            if (parts.size() == 4) begin
                word = {parts[0], parts[1], parts[2], parts[3]};
                parts.delete();
                collecting = 0;
                if (mq.size() < DEPTH) mq.push_back(word);
                else e_ovf = 1;
            end
        end
        if (v && c) begin
            parts.delete();
            collecting = (d == 8'hC0);
            if (start) begin
                e_ovf = 0; e_frm = 0; e_start = 1;
                e_22k = (d == 8'hC5);
            end
            if (d == 8'hC4) e_end = 1;
            if (flush) mq.delete();
        end
        if (fset) e_frm = 1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        check({tag, ".out_data"}, out_data, e_data);
        check({tag, ".start"}, 32'(audio_start_out), 32'(e_start));
        check({tag, ".end"}, 32'(audio_end_out), 32'(e_end));
        check({tag, ".22k"}, 32'(audio_22k_out), 32'(e_22k));
        check({tag, ".level"}, 32'(fifo_level), mq.size());
        check({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
        check({tag, ".framing"}, 32'(framing_err), 32'(e_frm));
        check({tag, ".underrun"}, 32'(underrun), 32'(e_under));
    endtask

    task automatic step(input string tag, input bit v, input logic [7:0] d, input bit c, input bit r);
        rx_valid = v; rx_data = d; rx_is_cmd = c; sample_req = r;
        model_step(v, d, c, r);
        @(posedge in_clk);
        #1;
        rx_valid = 0; rx_is_cmd = 0; sample_req = 0;
        compare_all(tag);
    endtask

    task automatic cmd(input string tag, input logic [7:0] d);
        step(tag, 1, d, 1, 0);
    endtask

    task automatic dat(input string tag, input logic [7:0] d);
        step(tag, 1, d, 0, 0);
    endtask

    task automatic req(input string tag);
        step(tag, 0, 8'h00, 0, 1);
        step(tag, 0, 8'h00, 0, 0);
    endtask

    task automatic sample(input string tag, input logic [31:0] w);
        cmd(tag, 8'hC0);
        dat(tag, w[31:24]);
        dat(tag, w[23:16]);
        dat(tag, w[15:8]);
        dat(tag, w[7:0]);
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset = 1;
        #1;
        model_reset();
        compare_all({tag, ".async"});
        @(negedge in_clk);
        reset = 0;
        @(posedge in_clk);
        #1;
    endtask

    initial begin
        bit          pend_v;
        int          pending;
        int          gap;
        int          sel;
        logic [7:0]  b;
        logic [31:0] w;

        model_reset();
        repeat (2) @(posedge in_clk);
        #1;
        compare_all("reset");
        reset = 0;
        @(posedge in_clk);
        #1;

        // basic 44k sample round trip
        cmd("start44", 8'hC7);
        sample("smp1", 32'h12345678);
        check("smp1.level_is_1", 32'(fifo_level), 32'd1);
        req("req1");

        // 22k, overflow, drain in order, then underrun or silence
        cmd("start22", 8'hC5);
        for (int k = 1; k <= 5; k++) sample("fill", 32'h01010101 * k);
        check("fill.overflow_set", 32'(overflow), 32'd1);
        for (int k = 1; k <= 5; k++) req("drain");

        // framing error from a command mid-sample, then end flush
        sample("pre_end", 32'hCAFEF00D);
        cmd("part", 8'hC0);
        dat("part", 8'hAA);
        dat("part", 8'hBB);
        cmd("end_mid", 8'hC4);
        check("end_mid.framing", 32'(framing_err), 32'd1);

        // full FIFO: completing byte and request in the same cycle
        cmd("start44b", 8'hC7);
        for (int k = 0; k < DEPTH; k++) sample("full", 32'hA0B0C0D0 + k);
        cmd("full_push", 8'hC0);
        dat("full_push", 8'h11);
        dat("full_push", 8'h22);
        dat("full_push", 8'h33);
        step("full_push_pop", 1, 8'h44, 0, 1);
        check("full_push_pop.ovf_clear", 32'(overflow), 32'd0);
        for (int k = 0; k < DEPTH + 1; k++) req("full_drain");

        // empty FIFO: completing byte and request in the same cycle
        cmd("empty_push", 8'hC0);
        dat("empty_push", 8'h55);
        dat("empty_push", 8'h66);
        dat("empty_push", 8'h77);
        step("empty_push_pop", 1, 8'h88, 0, 1);
        req("empty_drain");

        // stray data byte, unknown command, request coinciding with flush
        dat("stray", 8'h42);
        cmd("unknown", 8'hD3);
        sample("pre_flush", 32'h0BADBEEF);
        step("flush_pop", 1, 8'hC4, 1, 1);
        step("flush_pop_after", 0, 8'h00, 0, 0);

        // reset in the middle of a sample
        cmd("pre_rst", 8'hC5);
        cmd("mid", 8'hC0);
        dat("mid", 8'hDE);
        dat("mid", 8'hAD);
        do_reset("mid_rst");
        sample("clean", 32'h5A5AA5A5);
        req("clean");

        // random traffic
        pending = 0;
        gap = 2;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = (gap >= 2) && ($urandom_range(99) < 30);
            gap = r ? 0 : gap + 1;
            pend_v = ($urandom_range(99) < 80);
            b = 8'($urandom);
            if (!pend_v) begin
                step("rnd_idle", 0, b, 0, r);
            end else if (pending > 0) begin
                if ($urandom_range(99) < 3) begin
                    step("rnd_break", 1, 8'hC0, 1, r);
                    pending = 4;
                end else begin
                    step("rnd_data", 1, b, 0, r);
                    pending--;
                end
            end else begin
                sel = $urandom_range(99);
                if (sel < 70) begin
                    step("rnd_smp", 1, 8'hC0, 1, r);
                    pending = 4;
                end else if (sel < 75) begin
                    step("rnd_s44", 1, 8'hC7, 1, r);
                end else if (sel < 80) begin
                    step("rnd_s22", 1, 8'hC5, 1, r);
                end else if (sel < 85) begin
                    step("rnd_end", 1, 8'hC4, 1, r);
                end else if (sel < 92) begin
                    step("rnd_stray", 1, b, 0, r);
                end else begin
                    step("rnd_cmd", 1, 8'hC8 | b, 1, r);
                end
            end
            if (i == 1500) begin
                do_reset("rnd_rst");
                pending = 0;
                gap = 2;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/next_audio_sample_decoder.md
Name: next_audio_sample_decoder

Overview:
- Sits directly upstream of the I2S sender, in the in_clk domain.
- Takes the byte stream decoded from the NeXT monitor link, recognises the sound command bytes, and assembles 4-byte stereo samples, MSB first, into 32-bit words.
- Buffers samples in a small FIFO and releases exactly one sample per sender request tick, so the sender's single holding register is never overwritten.
- Generates the start, end and rate strobes the sender consumes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CMD_START_44K, 8'hC7, command byte: start playback at 44.1 kHz.
- CMD_START_22K, 8'hC5, command byte: start playback at 22.05 kHz.
- CMD_END, 8'hC4, command byte: stop playback.
- CMD_SAMPLE, 8'hC0, command byte: the next 4 data bytes form one sample.

Ports:
- in_clk  input  1  sole clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  one-cycle strobe; rx_data and rx_is_cmd are valid.
- rx_data  input  8  received byte.
- rx_is_cmd  input  1  1 = command byte, 0 = data byte.
- sample_req  input  1  one-cycle request from the sender (its req tick).
- out_valid  output  1  one-cycle strobe; out_data holds the sample.
- out_data  output  32  sample word, left channel in [31:16].
- audio_start_out  output  1  one-cycle start strobe.
- audio_end_out  output  1  one-cycle end strobe.
- audio_22k_out  output  1  rate level: 1 = 22 kHz, 0 = 44 kHz.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: a sample was dropped because the FIFO was full.
- framing_err  output  1  sticky: a command arrived mid-sample, or a data byte arrived outside a sample.
- underrun  output  1  one-cycle pulse: sample_req arrived while the FIFO was empty.

Behaviour:
- Reset: every output 0; FIFO empty; assembler in IDLE; both sticky flags cleared. Reset is asynchronous and may be asserted mid-operation: all state returns to these values, and partial samples and FIFO contents are discarded.
- Assembler FSM states: IDLE, B0, B1, B2, B3. Only cycles with rx_valid=1 advance it.
- In IDLE:
  - cmd = CMD_SAMPLE -> B0.
  - cmd = CMD_START_44K or CMD_START_22K -> FIFO flushed, audio_start_out pulses the next cycle, and audio_22k_out updates the same cycle (1 for START_22K, 0 for START_44K) and holds until the next start command.
  - cmd = CMD_END -> FIFO flushed, audio_end_out pulses the next cycle.
  - Any other command -> ignored.
  - Data byte -> set framing_err, byte discarded.
- B0..B3: each data byte is shifted into a 32-bit assembly register (first byte lands in [31:24]).
  - A data byte in B3 completes the word; push it to the FIFO and return to IDLE.
  - A command byte in B0..B3 discards the partial word, sets framing_err, and the command is then processed exactly as in IDLE (same cycle).
- FIFO push:
  - Push when full -> word dropped, overflow set.
  - Push and pop in the same cycle while full -> both occur; level unchanged; no overflow.
- FIFO pop, on sample_req=1:
  - Not empty: the head word is registered to out_data and out_valid pulses the next cycle (latency 1).
  - Empty: underrun pulses the next cycle; out_data holds its last value.
  - Push and pop in the same cycle while empty -> no bypass: underrun pulses, and the word is stored (level becomes 1).
- A flush (start or end command) that coincides with a push or pop: the flush wins, level becomes 0, and no out_valid is produced that cycle.
- out_valid never pulses on two consecutive cycles; sample_req is at least 2 cycles apart by construction of the sender.
- Pointers wrap modulo DEPTH. fifo_level spans 0..DEPTH and updates the cycle after the push or pop.
- Sticky flags clear only on reset or on a start command.

Optional Feature:
- Macro: DECODER_SILENCE_FILL_EN.
- Defined: sample_req on an empty FIFO produces out_valid with out_data = 32'h0000_0000 the next cycle (silence injection), and underrun still pulses.
- Undefined: no out_valid on an empty request, only the underrun pulse.

Test Plan:
- Reset, then C7, C0, 12, 34, 56, 78, then sample_req -> audio_start_out pulse, audio_22k_out=0, fifo_level 1, then out_valid with out_data=32'h12345678 one cycle after the request, fifo_level 0.
- C5, then 5 samples with DEPTH=4 and no requests -> audio_22k_out=1, fifo_level=4, overflow=1; 4 requests return samples 1..4 in order; a 5th request gives underrun (or zero data when DECODER_SILENCE_FILL_EN is defined).
- C0, AA, BB, then C4 -> framing_err=1, audio_end_out pulse, fifo_level 0, no sample pushed.
- FIFO full, with the last data byte of a sample and sample_req in the same cycle -> head word popped, new word stored, fifo_level stays 4, overflow stays 0.
- Empty FIFO, with the completing byte and sample_req in the same cycle -> underrun pulse, fifo_level 1, no out_valid.
- Reset asserted between B1 and B2, then C0 plus 4 bytes -> the clean new sample is stored, with no remnant of the old partial word.
